// File: rtl/kmeans_centroid_update_k3_d4_pkg.sv
// Shared k-means constants and width helpers for the centroid update block.
// Other k/d variants of the pipeline reuse this package.
package kmeans_pkg;

   localparam int K = 3;
   localparam int D = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic int sum_width(input int dw, input int qw);
      return dw + qw;
   endfunction

   function automatic int cnt_width(input int qw);
      return qw + 1;
   endfunction

endpackage

// File: rtl/kmeans_centroid_update_k3_d4_if.sv
// Point stream, current/new centroid buses and status for the centroid update block.
interface kmeans_centroid_update_k3_d4_if #(
   parameter int DW = 8
);
   logic          start;
   logic          in_valid;
   logic          in_last;
   logic [1:0]    in_centroid;
   logic [DW-1:0] in_d0, in_d1, in_d2, in_d3;
   logic [DW-1:0] cur_k0d0, cur_k0d1, cur_k0d2, cur_k0d3;
   logic [DW-1:0] cur_k1d0, cur_k1d1, cur_k1d2, cur_k1d3;
   logic [DW-1:0] cur_k2d0, cur_k2d1, cur_k2d2, cur_k2d3;
   logic [DW-1:0] new_k0d0, new_k0d1, new_k0d2, new_k0d3;
   logic [DW-1:0] new_k1d0, new_k1d1, new_k1d2, new_k1d3;
   logic [DW-1:0] new_k2d0, new_k2d1, new_k2d2, new_k2d3;
   logic          busy;
   logic          done;
   logic          converged;

   modport master (
      output start, in_valid, in_last, in_centroid,
      output in_d0, in_d1, in_d2, in_d3,
      output cur_k0d0, cur_k0d1, cur_k0d2, cur_k0d3,
      output cur_k1d0, cur_k1d1, cur_k1d2, cur_k1d3,
      output cur_k2d0, cur_k2d1, cur_k2d2, cur_k2d3,
      input  new_k0d0, new_k0d1, new_k0d2, new_k0d3,
      input  new_k1d0, new_k1d1, new_k1d2, new_k1d3,
      input  new_k2d0, new_k2d1, new_k2d2, new_k2d3,
      input  busy, done, converged
   );

   modport slave (
      input  start, in_valid, in_last, in_centroid,
      input  in_d0, in_d1, in_d2, in_d3,
      input  cur_k0d0, cur_k0d1, cur_k0d2, cur_k0d3,
      input  cur_k1d0, cur_k1d1, cur_k1d2, cur_k1d3,
      input  cur_k2d0, cur_k2d1, cur_k2d2, cur_k2d3,
      output new_k0d0, new_k0d1, new_k0d2, new_k0d3,
      output new_k1d0, new_k1d1, new_k1d2, new_k1d3,
      output new_k2d0, new_k2d1, new_k2d2, new_k2d3,
      output busy, done, converged
   );

endinterface

// File: rtl/kmeans_centroid_update_k3_d4_div.sv
// Unsigned restoring divider: one load cycle plus SW shift/subtract iterations.
// o_done and o_quot are valid in the last iteration cycle so the caller can latch on that edge.
module kmeans_seq_div #(
   parameter int SW = 16,
   parameter int CW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic [SW-1:0] i_dividend,
   input  logic [CW-1:0] i_divisor,
   output logic          o_done,
   output logic [SW-1:0] o_quot,
   output logic          o_div_zero
);
   localparam int NB = $clog2(SW + 1);

   logic [SW-1:0] r_q;
   logic [CW-1:0] r_rem;
   logic [CW-1:0] r_den;
   logic [NB-1:0] r_cnt;
   logic          r_busy;
   logic          r_dz;

   logic [CW:0]   w_sh;
   logic [CW:0]   w_diff;
   logic          w_ge;
   logic [CW-1:0] w_rem_nxt;
   logic [SW-1:0] w_q_nxt;

   // Remainder stays below the divisor, so CW bits hold it between steps.
   assign w_sh      = {r_rem, r_q[SW-1]};
   assign w_ge      = (w_sh >= {1'b0, r_den});
   assign w_diff    = w_sh - {1'b0, r_den};
   assign w_rem_nxt = w_ge ? w_diff[CW-1:0] : w_sh[CW-1:0];
   assign w_q_nxt   = {r_q[SW-2:0], w_ge};

   assign o_done     = r_busy && (r_cnt == NB'(1));
   assign o_quot     = w_q_nxt;
   assign o_div_zero = r_dz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q    <= '0;
         r_rem  <= '0;
         r_den  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_dz   <= 1'b0;
      end else if (i_start) begin
         r_q    <= i_dividend;
         r_rem  <= '0;
         r_den  <= i_divisor;
         r_cnt  <= NB'(SW);
         r_busy <= 1'b1;
         r_dz   <= (i_divisor == '0);
      end else if (r_busy) begin
         r_q   <= w_q_nxt;
         r_rem <= w_rem_nxt;
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == NB'(1)) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/kmeans_centroid_update_k3_d4.sv
// K-means centroid update: per-centroid sums/counts over one pass, then 12 sequential
// divisions into new centroids plus a convergence flag against the current centroids.
module kmeans_centroid_update_k3_d4
   import kmeans_pkg::*;
#(
   parameter int input_data_width         = 8,
   parameter int input_data_qty_bit_width = 8
) (
   input  logic clk,
   input  logic rst,
   kmeans_centroid_update_k3_d4_if.slave io_bus
);
   // state  | meaning
   // S_IDLE | waiting for start, outputs hold last results
   // S_ACC  | accumulating classified points into sums/counts
   // S_DIV  | dividing element idx = k*D+d, one divider slot each
   // S_DONE | one-cycle done pulse, converged registered

   localparam int DW = input_data_width;
   localparam int QW = input_data_qty_bit_width;
   localparam int SW = sum_width(DW, QW);
   localparam int CW = cnt_width(QW);
   localparam int KB = (K > 1) ? $clog2(K) : 1;
   localparam int DB = (D > 1) ? $clog2(D) : 1;
   localparam logic [1:0]    K_MAX_IDX = 2'(K - 1);
   localparam logic [KB-1:0] K_LAST    = KB'(K - 1);
   localparam logic [DB-1:0] D_LAST    = DB'(D - 1);

   state_t r_state, w_state_nxt;

   logic [SW-1:0] r_sum [K][D];
   logic [CW-1:0] r_cnt [K];
   logic [DW-1:0] r_new [K][D];
   logic          r_conv;
   logic [KB-1:0] r_k;
   logic [DB-1:0] r_d;
   logic          r_load;

   logic [DW-1:0] w_cur  [K][D];
   logic [DW-1:0] w_in_d [D];
   logic          w_clear;
   logic          w_acc;
   logic          w_div_start;
   logic          w_div_done;
   logic          w_div_dz;
   logic [SW-1:0] w_quot;
   logic          w_wr;
   logic [DW-1:0] w_wr_val;
   logic          w_all_eq;

   assign w_in_d[0] = io_bus.in_d0;
   assign w_in_d[1] = io_bus.in_d1;
   assign w_in_d[2] = io_bus.in_d2;
   assign w_in_d[3] = io_bus.in_d3;

   assign w_cur[0][0] = io_bus.cur_k0d0;
   assign w_cur[0][1] = io_bus.cur_k0d1;
   assign w_cur[0][2] = io_bus.cur_k0d2;
   assign w_cur[0][3] = io_bus.cur_k0d3;
   assign w_cur[1][0] = io_bus.cur_k1d0;
   assign w_cur[1][1] = io_bus.cur_k1d1;
   assign w_cur[1][2] = io_bus.cur_k1d2;
   assign w_cur[1][3] = io_bus.cur_k1d3;
   assign w_cur[2][0] = io_bus.cur_k2d0;
   assign w_cur[2][1] = io_bus.cur_k2d1;
   assign w_cur[2][2] = io_bus.cur_k2d2;
   assign w_cur[2][3] = io_bus.cur_k2d3;

   assign io_bus.new_k0d0 = r_new[0][0];
   assign io_bus.new_k0d1 = r_new[0][1];
   assign io_bus.new_k0d2 = r_new[0][2];
   assign io_bus.new_k0d3 = r_new[0][3];
   assign io_bus.new_k1d0 = r_new[1][0];
   assign io_bus.new_k1d1 = r_new[1][1];
   assign io_bus.new_k1d2 = r_new[1][2];
   assign io_bus.new_k1d3 = r_new[1][3];
   assign io_bus.new_k2d0 = r_new[2][0];
   assign io_bus.new_k2d1 = r_new[2][1];
   assign io_bus.new_k2d2 = r_new[2][2];
   assign io_bus.new_k2d3 = r_new[2][3];

   assign io_bus.busy      = (r_state == S_ACC) || (r_state == S_DIV);
   assign io_bus.done      = (r_state == S_DONE);
   assign io_bus.converged = r_conv;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_acc       = 1'b0;
      w_div_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.start) begin
               w_clear     = 1'b1;
               w_state_nxt = S_ACC;
            end
         end
         S_ACC: begin
            // start outranks a coincident point, which is dropped
            if (io_bus.start) begin
               w_clear = 1'b1;
            end else if (io_bus.in_valid) begin
               w_acc = (io_bus.in_centroid <= K_MAX_IDX);
               if (io_bus.in_last) begin
                  w_state_nxt = S_DIV;
               end
            end
         end
         S_DIV: begin
            w_div_start = r_load;
            if (w_div_done && (r_k == K_LAST) && (r_d == D_LAST)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (io_bus.start) begin
               w_clear     = 1'b1;
               w_state_nxt = S_ACC;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   kmeans_seq_div #(
      .SW (SW),
      .CW (CW)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_div_start),
      .i_dividend (r_sum[r_k][r_d]),
      .i_divisor  (r_cnt[r_k]),
      .o_done     (w_div_done),
      .o_quot     (w_quot),
      .o_div_zero (w_div_dz)
   );

   // An empty cluster keeps its current centroid; a mean never exceeds DW bits in contract.
   assign w_wr     = (r_state == S_DIV) && w_div_done;
   assign w_wr_val = w_div_dz ? w_cur[r_k][r_d] :
                     ((|w_quot[SW-1:DW]) ? '1 : w_quot[DW-1:0]);

   always_comb begin
      w_all_eq = 1'b1;
      for (int k = 0; k < K; k++) begin
         for (int d = 0; d < D; d++) begin
            w_all_eq &= (((w_wr && (r_k == KB'(k)) && (r_d == DB'(d))) ? w_wr_val : r_new[k][d])
                         == w_cur[k][d]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < K; k++) begin
            r_cnt[k] <= '0;
            for (int d = 0; d < D; d++) begin
               r_sum[k][d] <= '0;
               r_new[k][d] <= '0;
            end
         end
         r_conv <= 1'b0;
         r_k    <= '0;
         r_d    <= '0;
         r_load <= 1'b0;
      end else begin
         if (w_clear) begin
            for (int k = 0; k < K; k++) begin
               r_cnt[k] <= '0;
               for (int d = 0; d < D; d++) begin
                  r_sum[k][d] <= '0;
               end
            end
            r_conv <= 1'b0;
         end else if (w_acc) begin
            r_cnt[io_bus.in_centroid] <= r_cnt[io_bus.in_centroid] + 1'b1;
            for (int d = 0; d < D; d++) begin
               r_sum[io_bus.in_centroid][d] <= r_sum[io_bus.in_centroid][d] + SW'(w_in_d[d]);
            end
         end

         if ((r_state == S_ACC) && (w_state_nxt == S_DIV)) begin
            r_k    <= '0;
            r_d    <= '0;
            r_load <= 1'b1;
         end else if (w_div_start) begin
            r_load <= 1'b0;
         end else if (w_wr) begin
            r_new[r_k][r_d] <= w_wr_val;
            r_load          <= 1'b1;
            if (r_d == D_LAST) begin
               r_d <= '0;
               r_k <= r_k + 1'b1;
            end else begin
               r_d <= r_d + 1'b1;
            end
            if ((r_k == K_LAST) && (r_d == D_LAST)) begin
               r_conv <= w_all_eq;
            end
         end
      end
   end

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d4.sv
// Randomized bench for the centroid update block with a mean-of-stream reference model.
module tb_kmeans_centroid_update_k3_d4;
   localparam int DW      = 8;
   localparam int SW      = 16;
   localparam int DIV_CYC = 12 * (SW + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;

   int m_sum [3][4];
   int m_cnt [3];
   int m_cur [3][4];
   int s_c [300];
   int s_d [300][4];
   int s_n;

   kmeans_centroid_update_k3_d4_if #(.DW(DW)) bus ();

   kmeans_centroid_update_k3_d4 #(
      .input_data_width         (8),
      .input_data_qty_bit_width (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_cur();
      bus.cur_k0d0 = 8'(m_cur[0][0]); bus.cur_k0d1 = 8'(m_cur[0][1]);
      bus.cur_k0d2 = 8'(m_cur[0][2]); bus.cur_k0d3 = 8'(m_cur[0][3]);
      bus.cur_k1d0 = 8'(m_cur[1][0]); bus.cur_k1d1 = 8'(m_cur[1][1]);
      bus.cur_k1d2 = 8'(m_cur[1][2]); bus.cur_k1d3 = 8'(m_cur[1][3]);
      bus.cur_k2d0 = 8'(m_cur[2][0]); bus.cur_k2d1 = 8'(m_cur[2][1]);
      bus.cur_k2d2 = 8'(m_cur[2][2]); bus.cur_k2d3 = 8'(m_cur[2][3]);
   endtask

   function automatic int get_new(input int k, input int d);
      case (k * 4 + d)
         0:  return int'(bus.new_k0d0);
         1:  return int'(bus.new_k0d1);
         2:  return int'(bus.new_k0d2);
         3:  return int'(bus.new_k0d3);
         4:  return int'(bus.new_k1d0);
         5:  return int'(bus.new_k1d1);
         6:  return int'(bus.new_k1d2);
         7:  return int'(bus.new_k1d3);
         8:  return int'(bus.new_k2d0);
         9:  return int'(bus.new_k2d1);
         10: return int'(bus.new_k2d2);
         default: return int'(bus.new_k2d3);
      endcase
   endfunction

   function automatic int exp_new(input int k, input int d);
      if (m_cnt[k] == 0) return m_cur[k][d];
      return m_sum[k][d] / m_cnt[k];
   endfunction

   task automatic random_cur();
      for (int k = 0; k < 3; k++)
         for (int d = 0; d < 4; d++) m_cur[k][d] = $urandom_range(0, 255);
      apply_cur();
   endtask

   task automatic drive_idle();
      bus.start       = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_last     = 1'b0;
      bus.in_centroid = 2'($urandom_range(0, 3));
      bus.in_d0 = 8'($urandom); bus.in_d1 = 8'($urandom);
      bus.in_d2 = 8'($urandom); bus.in_d3 = 8'($urandom);
   endtask

   task automatic do_start(input bit with_point);
      drive_idle();
      bus.start    = 1'b1;
      bus.in_valid = with_point;
      bus.in_centroid = 2'($urandom_range(0, 2));
      tick();
      drive_idle();
      for (int k = 0; k < 3; k++) begin
         m_cnt[k] = 0;
         for (int d = 0; d < 4; d++) m_sum[k][d] = 0;
      end
      n_total++;
      if (bus.busy !== 1'b1) begin
         n_bad++;
         $display("FAIL start_busy: busy=%b required 1", bus.busy);
      end
   endtask

   task automatic gen_stream(input int n, input int pct3, input int c_fix, input int dval);
      s_n = n;
      for (int i = 0; i < n; i++) begin
         if (c_fix >= 0) s_c[i] = c_fix;
         else if (int'($urandom_range(0, 99)) < pct3) s_c[i] = 3;
         else s_c[i] = $urandom_range(0, 2);
         for (int d = 0; d < 4; d++) s_d[i][d] = (dval >= 0) ? dval : int'($urandom_range(0, 255));
      end
   endtask

   task automatic send_stream(input bit gaps, input bit with_last);
      for (int i = 0; i < s_n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            drive_idle();
            tick();
         end
         bus.start       = 1'b0;
         bus.in_valid    = 1'b1;
         bus.in_last     = with_last && (i == s_n - 1);
         bus.in_centroid = 2'(s_c[i]);
         bus.in_d0 = 8'(s_d[i][0]); bus.in_d1 = 8'(s_d[i][1]);
         bus.in_d2 = 8'(s_d[i][2]); bus.in_d3 = 8'(s_d[i][3]);
         if (s_c[i] < 3) begin
            m_cnt[s_c[i]]++;
            for (int d = 0; d < 4; d++) m_sum[s_c[i]][d] += s_d[i][d];
         end
         tick();
      end
      drive_idle();
   endtask

   // Entered at #1 after the edge that sampled in_last.
   task automatic wait_done(input string name, input int pre);
      int n;
      bit conv;
      n = pre;
      while (bus.done !== 1'b1 && n < DIV_CYC + 50) begin
         tick();
         n++;
      end
      n_total++;
      if (n != DIV_CYC) begin
         n_bad++;
         $display("FAIL %s_done_cycle: after=%0d required=%0d", name, n, DIV_CYC);
      end
      n_total++;
      if (bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_busy_at_done: busy=%b required 0", name, bus.busy);
      end
      conv = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int d = 0; d < 4; d++) begin
            if (exp_new(k, d) != m_cur[k][d]) conv = 1'b0;
            n_total++;
            if (get_new(k, d) !== exp_new(k, d)) begin
               n_bad++;
               $display("FAIL %s_new_k%0dd%0d: got=%0d required=%0d", name, k, d, get_new(k, d), exp_new(k, d));
            end
         end
      end
      n_total++;
      if (bus.converged !== conv) begin
         n_bad++;
         $display("FAIL %s_converged: got=%b required=%b", name, bus.converged, conv);
      end
   endtask

   task automatic check_all_zero(input string name);
      for (int k = 0; k < 3; k++) begin
         for (int d = 0; d < 4; d++) begin
            n_total++;
            if (get_new(k, d) !== 0) begin
               n_bad++;
               $display("FAIL %s_new_k%0dd%0d: got=%0d required=0", name, k, d, get_new(k, d));
            end
         end
      end
      n_total++;
      if ({bus.busy, bus.done, bus.converged} !== 3'b000) begin
         n_bad++;
         $display("FAIL %s_status: busy/done/conv=%b required 000", name, {bus.busy, bus.done, bus.converged});
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive_idle();
         bus.start    = 1'($urandom_range(0, 1));
         bus.in_valid = 1'($urandom_range(0, 1));
         tick();
      end
      check_all_zero("reset_hold");
      drive_idle();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_idle();
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_last  = bus.in_valid & 1'($urandom_range(0, 1));
         tick();
      end
      drive_idle();
      check_all_zero("reset_release");
   endtask

   task automatic test_single_cluster();
      for (int k = 0; k < 3; k++)
         for (int d = 0; d < 4; d++) m_cur[k][d] = 0;
      apply_cur();
      gen_stream(4, 0, 1, -1);
      s_d[0][0] = 10; s_d[1][0] = 20; s_d[2][0] = 30; s_d[3][0] = 41;
      do_start(1'b0);
      send_stream(1'b0, 1'b1);
      wait_done("single", 0);
      n_total++;
      if (get_new(1, 0) !== 25) begin
         n_bad++;
         $display("FAIL single_k1d0_const: got=%0d required=25", get_new(1, 0));
      end
      tick();
      n_total++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL single_done_pulse: done/busy=%b required 00", {bus.done, bus.busy});
      end
   endtask

   task automatic test_full_dataset();
      random_cur();
      gen_stream(256, 0, 2, 255);
      do_start(1'b0);
      send_stream(1'b0, 1'b1);
      wait_done("full", 0);
      n_total++;
      if (get_new(2, 3) !== 255) begin
         n_bad++;
         $display("FAIL full_k2d3_const: got=%0d required=255", get_new(2, 3));
      end
   endtask

   task automatic test_convergence();
      int cnt;
      int sum;
      gen_stream(24, 0, -1, -1);
      s_c[0] = 0;
      for (int k = 0; k < 3; k++) begin
         for (int d = 0; d < 4; d++) begin
            cnt = 0;
            sum = 0;
            for (int i = 0; i < s_n; i++) begin
               if (s_c[i] == k) begin
                  cnt++;
                  sum += s_d[i][d];
               end
            end
            m_cur[k][d] = (cnt > 0) ? sum / cnt : int'($urandom_range(0, 255));
         end
      end
      apply_cur();
      do_start(1'b0);
      send_stream(1'b1, 1'b1);
      wait_done("conv_exact", 0);
      n_total++;
      if (bus.converged !== 1'b1) begin
         n_bad++;
         $display("FAIL conv_exact_flag: got=%b required=1", bus.converged);
      end
      m_cur[0][3] = (m_cur[0][3] + 1) % 256;
      apply_cur();
      do_start(1'b0);
      send_stream(1'b1, 1'b1);
      wait_done("conv_perturb", 0);
      n_total++;
      if (bus.converged !== 1'b0) begin
         n_bad++;
         $display("FAIL conv_perturb_flag: got=%b required=0", bus.converged);
      end
   endtask

   task automatic test_centroid3_restart();
      random_cur();
      do_start(1'b0);
      gen_stream(8, 0, -1, 200);
      send_stream(1'b0, 1'b0);
      do_start(1'b1);
      gen_stream(20, 30, -1, -1);
      s_c[0] = 3;
      s_d[0][0] = 255; s_d[0][1] = 255; s_d[0][2] = 255; s_d[0][3] = 255;
      send_stream(1'b1, 1'b1);
      wait_done("cent3_restart", 0);
   endtask

   task automatic test_start_during_div();
      random_cur();
      do_start(1'b0);
      gen_stream(12, 10, -1, -1);
      send_stream(1'b1, 1'b1);
      for (int i = 0; i < 30; i++) begin
         drive_idle();
         bus.start       = 1'($urandom_range(0, 1));
         bus.in_valid    = 1'b1;
         bus.in_centroid = 2'($urandom_range(0, 2));
         tick();
      end
      drive_idle();
      wait_done("start_in_div", 30);
   endtask

   task automatic test_back_to_back();
      random_cur();
      do_start(1'b0);
      gen_stream(16, 0, -1, -1);
      send_stream(1'b0, 1'b1);
      wait_done("b2b_first", 0);
      do_start(1'b0);
      random_cur();
      gen_stream(16, 0, -1, -1);
      send_stream(1'b0, 1'b1);
      wait_done("b2b_second", 0);
   endtask

   task automatic test_reset_mid_div();
      random_cur();
      do_start(1'b0);
      gen_stream(10, 0, -1, -1);
      send_stream(1'b0, 1'b1);
      for (int i = 0; i < 40; i++) tick();
      rst = 1'b0;
      #1;
      check_all_zero("rst_mid_div");
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_idle();
         bus.in_valid = 1'($urandom_range(0, 1));
         tick();
      end
      drive_idle();
      check_all_zero("rst_mid_div_release");
   endtask

   initial begin
      drive_idle();
      for (int k = 0; k < 3; k++)
         for (int d = 0; d < 4; d++) m_cur[k][d] = 0;
      apply_cur();
      test_reset();
      test_single_cluster();
      test_full_dataset();
      test_convergence();
      test_centroid3_restart();
      test_start_during_div();
      test_back_to_back();
      test_reset_mid_div();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
